// File: rtl/alu_issue_seq.sv
// Issue-side sequencer: decodes a MIPS instruction onto a registered ALU, captures its result, returns a response.
// Optional: define ALU_OVF_CHK_EN to report signed overflow on ADD/ADDI/SUB.
module alu_issue_seq #(
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [5:0]    opcode,
   input  logic [5:0]    funct,
   input  logic [DW-1:0] rs_val,
   input  logic [DW-1:0] rt_val,
   input  logic [15:0]   imm,
   input  logic [4:0]    shamt_in,
   output logic [DW-1:0] alu_in1,
   output logic [DW-1:0] alu_in2,
   output logic [2:0]    alu_op,
   output logic [4:0]    alu_shamt,
   input  logic [DW-1:0] alu_out,
   input  logic          alu_zero,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_taken,
   output logic          rsp_illegal,
   output logic          rsp_ovf
);
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_SLL = 3'd4;
   localparam logic [2:0] OP_SRL = 3'd5;
   localparam logic [2:0] OP_CMP = 3'd6;
   localparam logic [2:0] OP_SLT = 3'd7;
   localparam int unsigned EXT_W = DW - 16;

   typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
   state_t state;

   logic          dec_legal;
   logic [2:0]    dec_op;
   logic [DW-1:0] dec_in1;
   logic [DW-1:0] dec_in2;
   logic [4:0]    dec_shamt;
   logic          dec_beq;
   logic          dec_bne;
   logic          br_beq;
   logic          br_bne;
   logic          ovf_c;
   logic [DW-1:0] imm_sext;
   logic [DW-1:0] imm_zext;

   assign imm_sext  = {{EXT_W{imm[15]}}, imm};
   assign imm_zext  = {{EXT_W{1'b0}}, imm};
   assign req_ready = (state == IDLE);

   // Instruction decode into ALU op and operand selection
   always_comb begin
      dec_legal = 1'b1;
      dec_op    = OP_ADD;
      dec_in1   = rs_val;
      dec_in2   = rt_val;
      dec_shamt = '0;
      dec_beq   = 1'b0;
      dec_bne   = 1'b0;
      case (opcode)
         6'h00: begin
            case (funct)
               6'h20: dec_op = OP_ADD;
               6'h22: dec_op = OP_SUB;
               6'h24: dec_op = OP_AND;
               6'h25: dec_op = OP_OR;
               6'h2A: dec_op = OP_SLT;
               6'h00: begin
                  dec_op    = OP_SLL;
                  dec_in1   = rt_val;
                  dec_in2   = '0;
                  dec_shamt = shamt_in;
               end
               6'h02: begin
                  dec_op    = OP_SRL;
                  dec_in1   = rt_val;
                  dec_in2   = '0;
                  dec_shamt = shamt_in;
               end
               default: dec_legal = 1'b0;
            endcase
         end
         6'h08, 6'h23, 6'h2B: dec_in2 = imm_sext;
         6'h0C: begin
            dec_op  = OP_AND;
            dec_in2 = imm_zext;
         end
         6'h0D: begin
            dec_op  = OP_OR;
            dec_in2 = imm_zext;
         end
         6'h04: begin
            dec_op  = OP_CMP;
            dec_beq = 1'b1;
         end
         6'h05: begin
            dec_op  = OP_CMP;
            dec_bne = 1'b1;
         end
         default: dec_legal = 1'b0;
      endcase
   end

`ifdef ALU_OVF_CHK_EN
   logic kind_add;
   logic kind_sub;

   // Operand signs stay visible on alu_in1/alu_in2; only the op class needs remembering
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kind_add <= 1'b0;
         kind_sub <= 1'b0;
      end else if (state == IDLE && req_valid && dec_legal) begin
         kind_add <= (opcode == 6'h08) || (opcode == 6'h00 && funct == 6'h20);
         kind_sub <= (opcode == 6'h00 && funct == 6'h22);
      end
   end

   assign ovf_c = (kind_add & (alu_in1[DW-1] == alu_in2[DW-1]) & (alu_out[DW-1] != alu_in1[DW-1]))
                | (kind_sub & (alu_in1[DW-1] != alu_in2[DW-1]) & (alu_out[DW-1] != alu_in1[DW-1]));
`else
   assign ovf_c = 1'b0;
`endif

   // Sequencer: IDLE -> EXEC -> CAPT -> RESP, illegal ops skip straight to RESP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         alu_in1     <= '0;
         alu_in2     <= '0;
         alu_op      <= '0;
         alu_shamt   <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_taken   <= 1'b0;
         rsp_illegal <= 1'b0;
         rsp_ovf     <= 1'b0;
         br_beq      <= 1'b0;
         br_bne      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (dec_legal) begin
                     alu_in1   <= dec_in1;
                     alu_in2   <= dec_in2;
                     alu_op    <= dec_op;
                     alu_shamt <= dec_shamt;
                     br_beq    <= dec_beq;
                     br_bne    <= dec_bne;
                     state     <= EXEC;
                  end else begin
                     rsp_illegal <= 1'b1;
                     rsp_data    <= '0;
                     rsp_taken   <= 1'b0;
                     rsp_ovf     <= 1'b0;
                     rsp_valid   <= 1'b1;
                     state       <= RESP;
                  end
               end
            end
            EXEC: state <= CAPT;
            CAPT: begin
               rsp_data    <= alu_out;
               rsp_taken   <= (br_beq & alu_zero) | (br_bne & ~alu_zero);
               rsp_illegal <= 1'b0;
               rsp_ovf     <= ovf_c;
               rsp_valid   <= 1'b1;
               state       <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
